// File: rtl/bus_read_buffer.sv
// Small FIFO feeding a shared tri-state read bus; producer pushes, decoder read_en pops.
// Latency: a pop at edge N drives out from edge N until N+1; a push at N is poppable at N+1.
// Backpressure: none; full push is dropped (sticky overflow), empty read drives zero (sticky underflow).
module bus_read_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             wr_en,
  input  logic             read_en,
  output wire  [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             drv_q, drv_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             do_push, do_pop;

  // Status is decoded only from registered count, never from this cycle's requests.
  assign count     = count_q;
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // The only combinational path: release the bus whenever no read was decoded last edge.
  assign out = drv_q ? dout_q : {WIDTH{1'bz}};

  // Next-state: push/pop qualification, pointers, count, bus word and sticky errors.
  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    dout_d  = dout_q;
    drv_d   = read_en;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    // A pop on a full FIFO frees the slot on the same edge, so the push still lands.
    do_pop  = read_en && !empty;
    do_push = wr_en && (!full || do_pop);

    if (do_push) begin
      mem_d[wp_q] = in;
      wp_d        = wp_q + 1'b1;
    end

    if (read_en) begin
      if (do_pop) begin
        dout_d = mem_q[rp_q];
        rp_d   = rp_q + 1'b1;
      end else begin
        // Empty read still drives zeros so a decoded read never floats.
        dout_d = '0;
      end
    end

    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    // Clear first so a same-cycle new error wins.
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en && full && !read_en) ovf_d = 1'b1;
    if (read_en && empty)          unf_d = 1'b1;
  end

  // Storage array: not reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state with synchronous reset; reset also drops any word latched for driving.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      dout_q  <= '0;
      drv_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      drv_q   <= drv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_bus_read_buffer.sv
// Directed bench for bus_read_buffer (WIDTH=8, DEPTH=4).
// Bus is pulled up, so a released bus reads as 8'hFF; driven data never uses 8'hFF.
// Inputs change #1 after the rising edge, outputs are sampled #1 after the next edge.
module tb_bus_read_buffer;

  localparam logic [7:0] ZB = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       wr_en;
  logic       read_en;
  logic       clr_err;
  wire  [7:0] bus;
  logic       full, empty, overflow, underflow;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus[g]);
  end

  bus_read_buffer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .wr_en(wr_en), .read_en(read_en),
    .out(bus), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       wr;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    logic [7:0] e_out;
    logic [2:0] e_cnt;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic rstn, input logic wr, input logic [7:0] d,
                              input logic rd, input logic clr, input logic [7:0] e_out,
                              input logic [2:0] e_cnt, input logic e_full, input logic e_empty,
                              input logic e_ovf, input logic e_unf);
    vec_t v;
    v.rstn = rstn; v.wr = wr; v.d = d; v.rd = rd; v.clr = clr;
    v.e_out = e_out; v.e_cnt = e_cnt; v.e_full = e_full; v.e_empty = e_empty;
    v.e_ovf = e_ovf; v.e_unf = e_unf;
    vt.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  // Apply one cycle of inputs, let one edge pass, sample after it.
  task automatic step(input logic rstn, input logic wr, input logic [7:0] d,
                      input logic rd, input logic clr);
    rst_n = rstn; wr_en = wr; din = d; read_en = rd; clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input vec_t v);
    chk({tag, ".out"},   idx, 32'(bus),       32'(v.e_out));
    chk({tag, ".count"}, idx, 32'(count),     32'(v.e_cnt));
    chk({tag, ".full"},  idx, 32'(full),      32'(v.e_full));
    chk({tag, ".empty"}, idx, 32'(empty),     32'(v.e_empty));
    chk({tag, ".ovf"},   idx, 32'(overflow),  32'(v.e_ovf));
    chk({tag, ".unf"},   idx, 32'(underflow), 32'(v.e_unf));
  endtask

  initial begin
    vec_t v;
    int   max_cnt;

    rst_n = 1'b0; wr_en = 1'b0; din = 8'h00; read_en = 1'b0; clr_err = 1'b0;

    //   rstn wr d      rd clr  out    cnt f  e  ovf unf
    add(0, 0, 8'h00, 0, 0, ZB,    0, 0, 1, 0, 0);  // reset
    add(0, 0, 8'h00, 0, 0, ZB,    0, 0, 1, 0, 0);  // reset, 2nd cycle
    add(1, 0, 8'h00, 0, 0, ZB,    0, 0, 1, 0, 0);  // idle after release
    add(1, 1, 8'hA1, 0, 0, ZB,    1, 0, 0, 0, 0);
    add(1, 1, 8'hA2, 0, 0, ZB,    2, 0, 0, 0, 0);
    add(1, 1, 8'hA3, 0, 0, ZB,    3, 0, 0, 0, 0);
    add(1, 1, 8'hA4, 0, 0, ZB,    4, 1, 0, 0, 0);
    add(1, 1, 8'hFF, 0, 0, ZB,    4, 1, 0, 1, 0);  // push while full: dropped
    add(1, 0, 8'h00, 1, 0, 8'hA1, 3, 0, 0, 1, 0);
    add(1, 0, 8'h00, 1, 0, 8'hA2, 2, 0, 0, 1, 0);
    add(1, 0, 8'h00, 1, 0, 8'hA3, 1, 0, 0, 1, 0);
    add(1, 0, 8'h00, 1, 0, 8'hA4, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 0, 0, ZB,    0, 0, 1, 1, 0);  // bus released
    add(1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 1, 1);  // empty read drives zero
    add(1, 0, 8'h00, 0, 1, ZB,    0, 0, 1, 0, 0);  // clear both flags
    add(1, 1, 8'hB1, 0, 0, ZB,    1, 0, 0, 0, 0);
    add(1, 1, 8'hB2, 0, 0, ZB,    2, 0, 0, 0, 0);
    add(1, 1, 8'hB3, 0, 0, ZB,    3, 0, 0, 0, 0);
    add(1, 1, 8'hB4, 0, 0, ZB,    4, 1, 0, 0, 0);
    add(1, 1, 8'h55, 1, 0, 8'hB1, 4, 1, 0, 0, 0);  // push+pop while full
    add(1, 0, 8'h00, 1, 0, 8'hB2, 3, 0, 0, 0, 0);
    add(1, 0, 8'h00, 1, 0, 8'hB3, 2, 0, 0, 0, 0);
    add(1, 0, 8'h00, 1, 0, 8'hB4, 1, 0, 0, 0, 0);
    add(1, 0, 8'h00, 1, 0, 8'h55, 0, 0, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, ZB,    0, 0, 1, 0, 0);
    add(1, 1, 8'h77, 1, 0, 8'h00, 1, 0, 0, 0, 1);  // push+read while empty: no fall-through
    add(1, 0, 8'h00, 1, 0, 8'h77, 0, 0, 1, 0, 1);
    add(1, 0, 8'h00, 1, 1, 8'h00, 0, 0, 1, 0, 1);  // clear vs new error: set wins
    add(1, 0, 8'h00, 0, 1, ZB,    0, 0, 1, 0, 0);

    foreach (vt[i]) begin
      v = vt[i];
      step(v.rstn, v.wr, v.d, v.rd, v.clr);
      chk_all("vec", i, v);
    end

    // Pointer wrap: alternating push/pop of 01..0A.
    max_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, 8'(i), 0, 0);
      chk("wrap.push_bus", i, 32'(bus), 32'(ZB));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      step(1, 0, 8'h00, 1, 0);
      chk("wrap.pop_bus", i, 32'(bus), 32'(i));
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    chk("wrap.max_count", 0, 32'(max_cnt), 32'd1);
    chk("wrap.underflow", 0, 32'(underflow), 32'd0);

    // Reset mid-read: in-flight word must not reach the bus.
    step(1, 0, 8'h00, 1, 0);                    // empty read sets underflow
    chk("mid.unf_set", 0, 32'(underflow), 32'd1);
    step(1, 1, 8'hC1, 0, 0);
    step(1, 1, 8'hC2, 0, 0);
    step(1, 0, 8'h00, 1, 0);
    chk("mid.first_word", 0, 32'(bus), 32'hC1);
    step(0, 0, 8'h00, 1, 0);                    // reset wins over read_en
    chk("mid.bus_z",  0, 32'(bus),       32'(ZB));
    chk("mid.count",  0, 32'(count),     32'd0);
    chk("mid.empty",  0, 32'(empty),     32'd1);
    chk("mid.unf_rst",0, 32'(underflow), 32'd0);
    step(1, 0, 8'h00, 0, 0);
    chk("mid.idle_z", 0, 32'(bus),       32'(ZB));
    step(1, 1, 8'hD1, 0, 0);
    step(1, 0, 8'h00, 1, 0);
    chk("mid.after_rst_word", 0, 32'(bus), 32'hD1);
    chk("mid.after_rst_count", 0, 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
